fetch_ctrl: RTL and testbench

Instruction-fetch controller for the five-stage MIPS pipeline. Owns the F-stage program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the F/D pipeline register. Sequences stall holds from the hazard unit, branch/jump redirects from the D stage (delay-slot semantics), and a one-entry pending-redirect buffer so a redirect is never lost during a stall.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_range_chk.sv | 25 ++
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The range/alignment check is enabled by defining FETCH_CHECK_EN.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEF = 4096;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: hazard/redirect inputs, instruction memory port and the F/D register outputs.
// The master modport is the fetch controller; the slave modport is the rest of the pipeline.
interface fetch_ctrl_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        d_valid;
  logic        fetch_err;

  modport master (
    input  stall, redirect_valid, redirect_pc, im_instr,
    output im_pc, d_instr, d_pc, d_pc8, d_valid, fetch_err
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, im_instr,
    input  im_pc, d_instr, d_pc, d_pc8, d_valid, fetch_err
  );

endinterface

// File: rtl/fetch_range_chk.sv
// Combinational PC checker: flags misaligned PCs and PCs outside the instruction memory window.
// Only instantiated when FETCH_CHECK_EN is defined.
module fetch_range_chk
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic [31:0] pc,
  output logic        fail
);

  // Upper bound computed in 33 bits so a window ending at 2^32 does not wrap.
  localparam logic [32:0] PC_END = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  logic misaligned;
  logic below;
  logic above;

  assign misaligned = (pc[1:0] != 2'b00);
  assign below      = (pc < RESET_PC);
  assign above      = ({1'b0, pc} >= PC_END);
  assign fail       = misaligned | below | above;

endmodule

// File: rtl/fetch_ctrl.sv
// F-stage fetch controller: PC register, F/D capture, stall holds and a one-entry pending redirect.
// Defining FETCH_CHECK_EN adds the PC range/alignment check and the HALT state.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  // state | meaning
  // BOOT  | first cycle after reset release; captures RESET_PC regardless of stall
  // RUN   | free-running fetch, captures every cycle stall is low
  // HOLD  | stalled; PC and F/D frozen, redirects land in the pending buffer
  // HALT  | a capture failed the range check; frozen until reset

  fetch_state_e state_q, state_d;
  logic [31:0]  f_pc_q, f_pc_d;
  logic [31:0]  d_instr_q, d_instr_d;
  logic [31:0]  d_pc_q, d_pc_d;
  logic         d_valid_q, d_valid_d;
  logic         err_q, err_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         capture;
  logic         chk_fail;
  logic [31:0]  pc_next;

`ifdef FETCH_CHECK_EN
  fetch_range_chk #(
    .RESET_PC (RESET_PC),
    .IM_WORDS (IM_WORDS)
  ) u_range_chk (
    .pc   (f_pc_q),
    .fail (chk_fail)
  );
`else
  assign chk_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      f_pc_q       <= RESET_PC;
      d_instr_q    <= NOP_INSTR;
      d_pc_q       <= 32'h0;
      d_valid_q    <= 1'b0;
      err_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      f_pc_q       <= f_pc_d;
      d_instr_q    <= d_instr_d;
      d_pc_q       <= d_pc_d;
      d_valid_q    <= d_valid_d;
      err_q        <= err_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // A live redirect beats a buffered one; the buffer is only ever full when leaving HOLD.
  always_comb begin
    pc_next = f_pc_q + 32'd4;
    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc;
    end else if (pend_valid_q) begin
      pc_next = pend_pc_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    f_pc_d       = f_pc_q;
    d_instr_d    = d_instr_q;
    d_pc_d       = d_pc_q;
    d_valid_d    = d_valid_q;
    err_d        = err_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    capture      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        capture = 1'b1;
        state_d = bus.stall ? ST_HOLD : ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (bus.stall) begin
          state_d = ST_HOLD;
          // Redirects arriving on any stalled cycle are kept so none is lost.
          if (bus.redirect_valid) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = bus.redirect_pc;
          end
        end else begin
          capture = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (capture) begin
      pend_valid_d = 1'b0;
      d_valid_d    = 1'b1;
      d_pc_d       = f_pc_q;
      if (chk_fail) begin
        d_instr_d = NOP_INSTR;
        err_d     = 1'b1;
        state_d   = ST_HALT;
      end else begin
        d_instr_d = bus.im_instr;
        f_pc_d    = pc_next;
      end
    end
  end

  assign bus.im_pc     = f_pc_q;
  assign bus.d_instr   = d_instr_q;
  assign bus.d_pc      = d_pc_q;
  assign bus.d_pc8     = d_pc_q + 32'd8;
  assign bus.d_valid   = d_valid_q;
`ifdef FETCH_CHECK_EN
  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed test-plan sequences plus randomized stall/redirect/reset traffic.
// A cycle-level reference model of the fetch rules is compared against the DUT on every falling edge.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (RST_PC),
    .IM_WORDS (4096)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic bad_pc(input logic [31:0] a);
`ifdef FETCH_CHECK_EN
    longint unsigned v;
    v = longint'(a);
    return (a[1:0] != 2'b00) || (v < 64'h3000) || (v >= 64'h3000 + 64'd4 * 64'd4096);
`else
    return (a == 32'h0) && (a != 32'h0);
`endif
  endfunction

  assign bus.im_instr = mem_word(bus.im_pc);

  // Reference model: what F PC and the F/D register must hold after each edge.
  logic [31:0] m_pc, m_dinstr, m_dpc, m_pp;
  logic        m_dvalid, m_err, m_pv, m_boot, m_halt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_dinstr <= '0; m_dpc <= '0; m_dvalid <= 1'b0;
      m_err <= 1'b0; m_pv <= 1'b0; m_pp <= '0; m_boot <= 1'b1; m_halt <= 1'b0;
    end else if (m_halt) begin
      m_halt <= 1'b1;
    end else if (m_boot || !bus.stall) begin
      m_boot   <= 1'b0;
      m_pv     <= 1'b0;
      m_dvalid <= 1'b1;
      m_dpc    <= m_pc;
      if (bad_pc(m_pc)) begin
        m_dinstr <= 32'h0;
        m_err    <= 1'b1;
        m_halt   <= 1'b1;
      end else begin
        m_dinstr <= mem_word(m_pc);
        m_pc     <= bus.redirect_valid ? bus.redirect_pc : (m_pv ? m_pp : m_pc + 32'd4);
      end
    end else if (bus.redirect_valid) begin
      m_pv <= 1'b1;
      m_pp <= bus.redirect_pc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("im_pc",     bus.im_pc,           m_pc);
    chk("d_instr",   bus.d_instr,         m_dinstr);
    chk("d_pc",      bus.d_pc,            m_dpc);
    chk("d_pc8",     bus.d_pc8,           m_dpc + 32'd8);
    chk("d_valid",   32'(bus.d_valid),    32'(m_dvalid));
    chk("fetch_err", 32'(bus.fetch_err),  32'(m_err));
  end

  // Inputs are applied just after a falling edge and held across the next rising edge.
  task automatic tick(input logic s, input logic rv, input logic [31:0] rp);
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_im_pc",   bus.im_pc,         RST_PC);
    chk("rst_d_pc",    bus.d_pc,          32'h0);
    chk("rst_d_pc8",   bus.d_pc8,         32'h8);
    chk("rst_d_valid", 32'(bus.d_valid),  32'h0);
    chk("rst_d_instr", bus.d_instr,       32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    @(negedge clk);
    @(negedge clk);
    chk("por_im_pc",   bus.im_pc,        32'h3000);
    chk("por_d_pc8",   bus.d_pc8,        32'h8);
    chk("por_d_valid", 32'(bus.d_valid), 32'h0);
    #2 rst_n = 1'b1;

    // Sequential fetch after reset
    tick(1'b0, 1'b0, 32'h0);
    chk("seq_im_pc1",  bus.im_pc,        32'h3004);
    chk("seq_d_pc1",   bus.d_pc,         32'h3000);
    chk("seq_d_pc8",   bus.d_pc8,        32'h3008);
    chk("seq_d_valid", 32'(bus.d_valid), 32'h1);
    tick(1'b0, 1'b0, 32'h0);
    chk("seq_im_pc2",  bus.im_pc,        32'h3008);
    chk("seq_d_pc2",   bus.d_pc,         32'h3004);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("pre_redir",   bus.im_pc,        32'h3010);

    // Redirect keeps the delay slot
    tick(1'b0, 1'b1, 32'h3100);
    chk("dslot_d_pc",  bus.d_pc,         32'h3010);
    chk("redir_im_pc", bus.im_pc,        32'h3100);
    tick(1'b0, 1'b0, 32'h0);
    chk("redir_next",  bus.im_pc,        32'h3104);
    chk("redir_d_pc",  bus.d_pc,         32'h3100);

    // Stall 3 cycles with a redirect in the second
    tick(1'b0, 1'b1, 32'h3020);
    tick(1'b1, 1'b0, 32'h0);
    chk("stall_d1",    bus.d_pc,         32'h3104);
    tick(1'b1, 1'b1, 32'h3200);
    chk("stall_d2",    bus.d_pc,         32'h3104);
    tick(1'b1, 1'b0, 32'h0);
    chk("stall_d3",    bus.d_pc,         32'h3104);
    chk("stall_im",    bus.im_pc,        32'h3020);
    tick(1'b0, 1'b0, 32'h0);
    chk("rel_d_pc",    bus.d_pc,         32'h3020);
    chk("rel_im_pc",   bus.im_pc,        32'h3200);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("pend_empty",  bus.im_pc,        32'h3204);

    // Newest pending redirect wins; a live redirect beats the pending one
    tick(1'b1, 1'b1, 32'h3200);
    tick(1'b1, 1'b1, 32'h3300);
    tick(1'b0, 1'b0, 32'h0);
    chk("two_redir",   bus.im_pc,        32'h3300);
    tick(1'b1, 1'b1, 32'h3500);
    tick(1'b0, 1'b1, 32'h3600);
    chk("live_prio",   bus.im_pc,        32'h3600);

    // Asynchronous reset mid-run
    tick(1'b0, 1'b1, 32'h3040);
    chk("pre_rst",     bus.im_pc,        32'h3040);
    reset_pulse();
    tick(1'b0, 1'b0, 32'h0);
    chk("restart_im",  bus.im_pc,        32'h3004);
    chk("restart_d",   bus.d_pc,         32'h3000);

`ifdef FETCH_CHECK_EN
    tick(1'b0, 1'b1, 32'h3002);
    tick(1'b0, 1'b0, 32'h0);
    chk("mis_err",     32'(bus.fetch_err), 32'h1);
    chk("mis_d_pc",    bus.d_pc,         32'h3002);
    chk("mis_d_instr", bus.d_instr,      32'h0);
    tick(1'b1, 1'b1, 32'h3000);
    tick(1'b0, 1'b1, 32'h3000);
    chk("halt_d_pc",   bus.d_pc,         32'h3002);
    reset_pulse();
    tick(1'b0, 1'b1, 32'h7000);
    tick(1'b0, 1'b0, 32'h0);
    chk("oor_err",     32'(bus.fetch_err), 32'h1);
    chk("oor_d_pc",    bus.d_pc,         32'h7000);
    reset_pulse();
`else
    // Address wrap at the top of the 32-bit space
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 32'h0);
    chk("wrap_im_pc",  bus.im_pc,        32'h0);
    chk("wrap_d_pc8",  bus.d_pc8,        32'h4);
    tick(1'b0, 1'b1, 32'h3001);
    tick(1'b0, 1'b0, 32'h0);
    chk("unaligned",   bus.im_pc,        32'h3005);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        s, rv;
      logic [31:0] rp;
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end
      s  = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 19) == 0) rp = $urandom;
      else rp = 32'h3000 + 32'($urandom_range(0, 4095)) * 32'd4;
      tick(s, rv, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
